// File: rtl/oam_dma_scheduler.sv
// Sprite DMA sequencer: on a trigger write it stalls the CPU and copies one
// 256-byte page to the OAM data port as read/write bus cycle pairs.
module oam_dma_scheduler #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] OAM_PORT     = 16'h2004,
    parameter bit          ALIGN_EN     = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_data_out,
    input  logic [7:0]  bus_data_in,
    output logic [15:0] bus_addr,
    output logic        bus_rw,
    output logic [7:0]  bus_data_out,
    output logic        dma_drive,
    output logic        cpu_stall,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state_q;
    logic        parity_q;
    logic [7:0]  page_q;
    logic [7:0]  idx_q;
    logic [7:0]  latch_q;
    logic        stall_q;
    logic        busy_q;
    logic        done_q;
    logic        drive_q;

    // Transfer sequencer; status outputs are registered alongside the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            latch_q  <= 8'h00;
            stall_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drive_q  <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!cpu_rw && (cpu_addr == TRIGGER_ADDR)) begin
                        page_q  <= cpu_data_out;
                        state_q <= S_HALT;
                        stall_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HALT: begin
                    // Reads must fall on even-parity cycles when alignment is enabled.
                    if (ALIGN_EN && !parity_q) begin
                        state_q <= S_ALIGN;
                    end else begin
                        state_q <= S_READ;
                    end
                end
                S_ALIGN: begin
                    state_q <= S_READ;
                end
                S_READ: begin
                    latch_q <= bus_data_in;
                    drive_q <= 1'b1;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    idx_q   <= idx_q + 8'd1;
                    drive_q <= 1'b0;
                    if (idx_q == 8'hFF) begin
                        state_q <= S_DONE;
                        stall_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_READ;
                    end
                end
                S_DONE: begin
                    idx_q   <= 8'h00;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    idx_q   <= 8'h00;
                    stall_q <= 1'b0;
                    busy_q  <= 1'b0;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    // Bus ownership mux: the CPU passes through except while the transfer holds the bus.
    always_comb begin
        bus_addr     = cpu_addr;
        bus_rw       = cpu_rw;
        bus_data_out = cpu_data_out;
        case (state_q)
            S_HALT, S_ALIGN: begin
                bus_rw = 1'b1;
            end
            S_READ: begin
                bus_addr = {page_q, idx_q};
                bus_rw   = 1'b1;
            end
            S_WRITE: begin
                bus_addr     = OAM_PORT;
                bus_rw       = 1'b0;
                bus_data_out = latch_q;
            end
            default: begin
                bus_addr     = cpu_addr;
                bus_rw       = cpu_rw;
                bus_data_out = cpu_data_out;
            end
        endcase
    end

    assign dma_drive = drive_q;
    assign cpu_stall = stall_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_oam_dma_scheduler.sv
// Scoreboard bench: two instances (alignment on / off) share the CPU side; a
// page-level reference model predicts transfers, a monitor checks bus activity.
module tb_oam_dma_scheduler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data_out;
    logic [15:0] bus_addr     [2];
    logic        bus_rw       [2];
    logic [7:0]  bus_data_out [2];
    logic [7:0]  bus_data_in  [2];
    logic        dma_drive    [2];
    logic        cpu_stall    [2];
    logic        busy         [2];
    logic        done         [2];
    logic [7:0]  mem [0:65535];

    always #5 Clk = ~Clk;

    assign bus_data_in[0] = mem[bus_addr[0]];
    assign bus_data_in[1] = mem[bus_addr[1]];

    oam_dma_scheduler #(.ALIGN_EN(1'b1)) dut_a (
        .Clk(Clk), .Reset(Reset), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .cpu_data_out(cpu_data_out), .bus_data_in(bus_data_in[0]),
        .bus_addr(bus_addr[0]), .bus_rw(bus_rw[0]), .bus_data_out(bus_data_out[0]),
        .dma_drive(dma_drive[0]), .cpu_stall(cpu_stall[0]), .busy(busy[0]), .done(done[0]));

    oam_dma_scheduler #(.ALIGN_EN(1'b0)) dut_b (
        .Clk(Clk), .Reset(Reset), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .cpu_data_out(cpu_data_out), .bus_data_in(bus_data_in[1]),
        .bus_addr(bus_addr[1]), .bus_rw(bus_rw[1]), .bus_data_out(bus_data_out[1]),
        .dma_drive(dma_drive[1]), .cpu_stall(cpu_stall[1]), .busy(busy[1]), .done(done[1]));

    typedef struct {
        int trig;
        int align;
    } run_t;

    run_t        runs0[$], runs1[$];
    logic [23:0] pairs0[$], pairs1[$];
    int          free_cyc [2];
    int          cyc = 0;
    logic        tpar = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // Monitor bookkeeping per instance
    bit          in_run      [2];
    int          stall_start [2];
    int          nwr         [2];
    int          first_rd    [2];
    int          last_rd_cyc [2];
    logic [15:0] last_rd_addr[2];
    logic        last_rd_par [2];

    // Reference cycle count and bus parity (toggles every clock, cleared by Reset).
    always @(posedge Clk) begin
        cyc  <= cyc + 1;
        tpar <= Reset ? 1'b0 : ~tpar;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a trigger is taken by an idle instance and yields 256 copies.
    task automatic model_trigger(input logic [7:0] pg);
        for (int d = 0; d < 2; d++) begin
            if (cyc >= free_cyc[d]) begin
                run_t r;
                r.trig  = cyc;
                r.align = (d == 0 && tpar == 1'b1) ? 1 : 0;
                if (d == 0) runs0.push_back(r); else runs1.push_back(r);
                for (int i = 0; i < 256; i++) begin
                    logic [15:0] a;
                    a = {pg, i[7:0]};
                    if (d == 0) pairs0.push_back({a, mem[a]});
                    else        pairs1.push_back({a, mem[a]});
                end
                free_cyc[d] = cyc + 515 + r.align;
            end
        end
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] dat);
        cpu_addr     = a;
        cpu_rw       = rw;
        cpu_data_out = dat;
        if (!rw && a == 16'h4014 && !Reset) model_trigger(dat);
        @(posedge Clk);
        #1;
    endtask

    task automatic rand_cycle(input bit spam);
        logic [15:0] a;
        logic        rw;
        logic [7:0]  dat;
        a   = 16'($urandom);
        rw  = 1'($urandom_range(0, 1));
        dat = 8'($urandom);
        if (spam && $urandom_range(0, 7) == 0) begin
            a  = 16'h4014;
            rw = 1'b0;
        end else if (a == 16'h4014) begin
            rw = 1'b1;
        end
        cpu_cycle(a, rw, dat);
    endtask

    task automatic run_until(input int c, input bit spam);
        while (cyc < c) rand_cycle(spam);
    endtask

    task automatic settle();
        run_until(((free_cyc[0] > free_cyc[1]) ? free_cyc[0] : free_cyc[1]) + 3, 1'b0);
    endtask

    task automatic trigger(input logic want_par, input logic [7:0] pg, output int t);
        while (tpar != want_par) rand_cycle(1'b0);
        t = cyc;
        cpu_cycle(16'h4014, 1'b0, pg);
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        runs0.delete(); runs1.delete(); pairs0.delete(); pairs1.delete();
        for (int i = 0; i < n; i++) cpu_cycle(16'h0000, 1'b1, 8'h00);
        for (int d = 0; d < 2; d++) begin
            chk("reset_stall", {31'd0, cpu_stall[d]}, 32'd0);
            chk("reset_busy",  {31'd0, busy[d]},      32'd0);
            chk("reset_drive", {31'd0, dma_drive[d]}, 32'd0);
            chk("reset_done",  {31'd0, done[d]},      32'd0);
        end
        Reset = 1'b0;
        free_cyc[0] = cyc;
        free_cyc[1] = cyc;
    endtask

    // Monitor: compares each observed OAM write and each completed stall window.
    task automatic mon(input int d);
        logic [23:0] e;
        run_t        r;
        bit          have;
        if (Reset) begin
            in_run[d] = 1'b0;
            return;
        end
        if (cpu_stall[d]) begin
            if (!in_run[d]) begin
                in_run[d]      = 1'b1;
                stall_start[d] = cyc;
                nwr[d]         = 0;
                first_rd[d]    = -1;
            end
            chk("busy_in_stall", {31'd0, busy[d]}, 32'd1);
            if (dma_drive[d]) begin
                have = (d == 0) ? (pairs0.size() != 0) : (pairs1.size() != 0);
                chk("write_expected", {31'd0, have}, 32'd1);
                if (have) begin
                    e = (d == 0) ? pairs0.pop_front() : pairs1.pop_front();
                    chk("oam_addr",   {16'd0, bus_addr[d]},     32'h2004);
                    chk("oam_rw",     {31'd0, bus_rw[d]},       32'd0);
                    chk("src_addr",   {16'd0, last_rd_addr[d]}, {16'd0, e[23:8]});
                    chk("oam_data",   {24'd0, bus_data_out[d]}, {24'd0, e[7:0]});
                    chk("read_write_adjacent", last_rd_cyc[d], cyc - 1);
                    if (d == 0) chk("read_parity", {31'd0, last_rd_par[d]}, 32'd0);
                    if (nwr[d] == 0) first_rd[d] = last_rd_cyc[d];
                    nwr[d]++;
                end
            end else begin
                chk("stall_bus_read", {31'd0, bus_rw[d]}, 32'd1);
                last_rd_addr[d] = bus_addr[d];
                last_rd_cyc[d]  = cyc;
                last_rd_par[d]  = tpar;
            end
        end else begin
            chk("pass_addr", {16'd0, bus_addr[d]}, {16'd0, cpu_addr});
            chk("pass_rw",   {31'd0, bus_rw[d]},   {31'd0, cpu_rw});
            chk("pass_data", {24'd0, bus_data_out[d]}, {24'd0, cpu_data_out});
            chk("idle_drive", {31'd0, dma_drive[d]}, 32'd0);
            chk("idle_busy",  {31'd0, busy[d]},      32'd0);
            if (in_run[d]) begin
                in_run[d] = 1'b0;
                have = (d == 0) ? (runs0.size() != 0) : (runs1.size() != 0);
                chk("run_expected", {31'd0, have}, 32'd1);
                chk("done_pulse", {31'd0, done[d]}, 32'd1);
                if (have) begin
                    r = (d == 0) ? runs0.pop_front() : runs1.pop_front();
                    chk("stall_len",   cyc - stall_start[d], 513 + r.align);
                    chk("stall_start", stall_start[d], r.trig + 1);
                    chk("first_read",  first_rd[d], r.trig + 2 + r.align);
                    chk("write_count", nwr[d], 256);
                end
            end else begin
                chk("spurious_done", {31'd0, done[d]}, 32'd0);
            end
        end
    endtask

    always @(negedge Clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        int t;
        Reset        = 1'b1;
        cpu_addr     = 16'h0000;
        cpu_rw       = 1'b1;
        cpu_data_out = 8'h00;
        free_cyc[0]  = 0;
        free_cyc[1]  = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        do_reset(3);

        // HALT on parity 1: no alignment anywhere
        trigger(1'b0, 8'h02, t);
        settle();
        // HALT on parity 0: aligning instance takes one extra cycle; spam triggers while busy
        trigger(1'b1, 8'h5C, t);
        run_until(t + 400, 1'b1);
        settle();
        // Top page with known contents
        for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = 8'(i) ^ 8'hA5;
        trigger(1'($urandom_range(0, 1)), 8'hFF, t);
        settle();
        // Reset in the cycle after the 100th OAM write, then a full copy
        trigger(1'b0, 8'h37, t);
        run_until(t + 202, 1'b0);
        do_reset(1);
        run_until(cyc + 4, 1'b0);
        trigger(1'b1, 8'h81, t);
        settle();
        // Trigger writes during busy and on the DONE cycle are ignored
        trigger(1'b0, 8'hC3, t);
        run_until(t + 514, 1'b1);
        cpu_cycle(16'h4014, 1'b0, 8'h11);
        settle();
        // Randomized pages and phases
        for (int k = 0; k < 3; k++) begin
            trigger(1'($urandom_range(0, 1)), 8'($urandom), t);
            run_until(t + 300, 1'b1);
            settle();
        end

        chk("left_runs_a",  runs0.size(),  0);
        chk("left_runs_b",  runs1.size(),  0);
        chk("left_pairs_a", pairs0.size(), 0);
        chk("left_pairs_b", pairs1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
